priority_scan_encoder: RTL and testbench
========================================

Name: priority_scan_encoder

Overview:
Parametrised, sequential successor to the fixed 8-to-3 priority encoder. It accepts a WIDTH-bit request vector over a valid/ready handshake. It then streams out the index of every set bit, one per cycle, in priority order, clearing each bit once its index is consumed. It serves as the general-purpose "find next set bit" engine for arbitration and interrupt-style scanning logic.

Parameters:
WIDTH, 8, request vector width; legal values are 2 to 64.
IDXW, $clog2(WIDTH), index width; derived from WIDTH and never overridden.
MSB_FIRST, 1, 1 gives the highest-numbered set bit the highest priority; 0 gives bit 0 the highest priority.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request vector offered
in_ready  output  1  block can accept a vector
in_data  input  WIDTH  request vector
out_valid  output  1  out_index valid
out_ready  input  1  consumer takes the current index
out_index  output  IDXW  index of the highest-priority pending bit
out_last  output  1  current beat is the final beat of this vector
out_none  output  1  vector was all-zero; single dummy beat
busy  output  1  scan in progress (state != IDLE)

Behaviour:
- Reset is asynchronous and active-low. One clock, clk.
- While rst_n=0: state=IDLE, pending=0, none_q=0, in_ready=1, out_valid=0, out_index=0, out_last=0, out_none=0, busy=0.
- States: IDLE and SCAN.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid&&in_ready at edge N: pending<=in_data, none_q<=(in_data==0), state<=SCAN.
  - out_valid is high from cycle N+1, giving a one-cycle latency.
- SCAN:
  - in_ready=0 (except as allowed by the optional feature), out_valid=1, busy=1.
  - out_index is combinational from registered pending: the highest set bit if MSB_FIRST=1, otherwise the lowest set bit.
  - out_last=1 when popcount(pending)<=1.
  - out_none=none_q. When none_q=1: out_index=0 and out_last=1.
- Handshake in SCAN: on out_valid&&out_ready, clear bit out_index in pending.
  - If out_last, state<=IDLE and none_q<=0.
  - Otherwise stay in SCAN; the next index appears the following cycle, for a throughput of one index per cycle.
- Stall: while out_ready=0, pending, out_index, out_last and out_none hold stable. out_valid never drops without a handshake.
- in_data and in_valid are ignored while in SCAN. The upstream source holds them under the handshake rule.
- Width rules:
  - out_index is zero-extended to IDXW.
  - When WIDTH is not a power of two, indices >= WIDTH never occur.
- Reset mid-scan: the scan aborts immediately, pending is lost, and all outputs return to their reset values. No beats are emitted after reset deasserts until a new vector is accepted.
- A new vector is never merged into an in-flight scan.

Optional Feature:
Macro PRIO_SCAN_BACK2BACK_EN.
- Defined: in_ready = (state==IDLE) || (out_valid && out_ready && out_last). A vector accepted in the same cycle as the last-beat handshake loads pending directly and stays in SCAN. This removes the IDLE bubble, so N vectors with one bit each stream at one beat per cycle.
- Not defined: in_ready=1 only in IDLE. Each vector therefore costs one idle cycle between the last beat and the next acceptance.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, in_data=8'd40 (0010_1000), out_ready=1 -> beats: index 5 (last=0), then index 3 (last=1), none=0, then IDLE. in_ready=0 for exactly 2 cycles.
2. in_data=8'd0 -> exactly one beat with out_none=1, out_index=0, out_last=1, then IDLE.
3. in_data=8'd150 (1001_0110), out_ready toggled 1,0,0,1,1,0,1 -> indices 7,4,2,1 in order. Outputs are held stable during each 0 cycle, and out_last is asserted only with index 1.
4. MSB_FIRST=0, in_data=8'd46 (0010_1110) -> indices 1,2,3,5, with last on 5. Separately, WIDTH=16, in_data=16'h8001 -> with MSB_FIRST=1: 15 then 0; with MSB_FIRST=0: 0 then 15.
5. Load 8'd255, pulse rst_n low for less than a cycle after the second beat -> out_valid drops immediately. The remaining six indices are never emitted, and in_ready=1 after reset deasserts.
6. With PRIO_SCAN_BACK2BACK_EN defined, in_valid held high with 8'd1, 8'd2, 8'd64 -> indices 0,1,6 on three consecutive cycles. Without the macro, there is a one-cycle gap between each.

Source files
------------

// File: rtl/priority_scan_encoder_if.sv
// Handshake bundle for priority_scan_encoder.
//   in_valid/in_ready/in_data           : request vector input channel
//   out_valid/out_ready/out_index       : index output channel
//   out_last/out_none                   : beat qualifiers
//   busy                                : scan in progress
// Modports: master = upstream/downstream environment, slave = encoder.
interface priority_scan_encoder_if #(
  parameter int WIDTH = 8
);
  localparam int IDXW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_index;
  logic             out_last;
  logic             out_none;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_index, out_last, out_none, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_index, out_last, out_none, busy
  );
endinterface

// File: rtl/priority_scan_encoder.sv
// priority_scan_encoder: accepts a WIDTH-bit request vector and streams the
// index of every set bit, one per cycle, in priority order.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : priority_scan_encoder_if.slave (in/out handshakes, busy)
// Parameters: WIDTH (2..64), MSB_FIRST (1: highest bit first, 0: bit 0 first).
// Optional macro PRIO_SCAN_BACK2BACK_EN: accept a new vector on the
// last-beat handshake cycle, removing the idle bubble between vectors.
module priority_scan_encoder #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  priority_scan_encoder_if.slave  bus
);
  localparam int IDXW = $clog2(WIDTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             none_q, none_d;

  logic [IDXW-1:0]  scan_idx;
  logic             single;
  logic             out_valid;
  logic             out_last;
  logic             out_fire;
  logic             in_ready;
  logic             in_fire;

  // Later loop iterations overwrite earlier ones, so the scan direction
  // decides which set bit wins.
  always_comb begin
    scan_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST != 0) begin
        if (pending_q[i]) scan_idx = IDXW'(i);
      end else begin
        if (pending_q[WIDTH-1-i]) scan_idx = IDXW'(WIDTH-1-i);
      end
    end
  end

  // popcount <= 1
  assign single    = (pending_q & (pending_q - WIDTH'(1))) == '0;
  assign out_valid = (state_q == SCAN);
  assign out_last  = out_valid && (none_q || single);
  assign out_fire  = out_valid && bus.out_ready;

`ifdef PRIO_SCAN_BACK2BACK_EN
  assign in_ready = (state_q == IDLE) || (out_fire && out_last);
`else
  assign in_ready = (state_q == IDLE);
`endif
  assign in_fire = bus.in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    none_d    = none_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          pending_d = bus.in_data;
          none_d    = (bus.in_data == '0);
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (out_fire) begin
          pending_d = pending_q & ~(WIDTH'(1) << scan_idx);
          if (out_last) begin
            state_d = IDLE;
            none_d  = 1'b0;
          end
        end
        // Back-to-back load: only reachable on the last-beat handshake,
        // so the drained vector is fully replaced rather than merged.
        if (in_fire) begin
          pending_d = bus.in_data;
          none_d    = (bus.in_data == '0);
          state_d   = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      none_q    <= none_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_index = out_valid ? scan_idx : '0;
  assign bus.out_last  = out_last;
  assign bus.out_none  = out_valid && none_q;
  assign bus.busy      = out_valid;
endmodule

// File: tb/tb_priority_scan_encoder.sv
module tb_priority_scan_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv = 1'b0;
  logic [15:0] din = '0;
  logic        ordy = 1'b0;
  int          sel = 0;

  int n_checks = 0;
  int n_err    = 0;

`ifdef PRIO_SCAN_BACK2BACK_EN
  localparam bit B2B = 1'b1;
  localparam int GAP = 1;
`else
  localparam bit B2B = 1'b0;
  localparam int GAP = 2;
`endif

  always #5 clk = ~clk;

  // 0: W8 MSB-first, 1: W8 LSB-first, 2: W16 MSB-first, 3: W16 LSB-first
  priority_scan_encoder_if #(.WIDTH(8))  b0 ();
  priority_scan_encoder_if #(.WIDTH(8))  b1 ();
  priority_scan_encoder_if #(.WIDTH(16)) b2 ();
  priority_scan_encoder_if #(.WIDTH(16)) b3 ();

  assign b0.in_valid = iv;  assign b0.in_data = din[7:0]; assign b0.out_ready = ordy;
  assign b1.in_valid = iv;  assign b1.in_data = din[7:0]; assign b1.out_ready = ordy;
  assign b2.in_valid = iv;  assign b2.in_data = din;      assign b2.out_ready = ordy;
  assign b3.in_valid = iv;  assign b3.in_data = din;      assign b3.out_ready = ordy;

  priority_scan_encoder #(.WIDTH(8),  .MSB_FIRST(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  priority_scan_encoder #(.WIDTH(8),  .MSB_FIRST(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  priority_scan_encoder #(.WIDTH(16), .MSB_FIRST(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  priority_scan_encoder #(.WIDTH(16), .MSB_FIRST(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  logic       o_ir, o_ov, o_last, o_none, o_busy;
  logic [5:0] o_idx;

  always_comb begin
    o_ir = b0.in_ready; o_ov = b0.out_valid; o_idx = 6'(b0.out_index);
    o_last = b0.out_last; o_none = b0.out_none; o_busy = b0.busy;
    case (sel)
      1: begin
        o_ir = b1.in_ready; o_ov = b1.out_valid; o_idx = 6'(b1.out_index);
        o_last = b1.out_last; o_none = b1.out_none; o_busy = b1.busy;
      end
      2: begin
        o_ir = b2.in_ready; o_ov = b2.out_valid; o_idx = 6'(b2.out_index);
        o_last = b2.out_last; o_none = b2.out_none; o_busy = b2.busy;
      end
      3: begin
        o_ir = b3.in_ready; o_ov = b3.out_valid; o_idx = 6'(b3.out_index);
        o_last = b3.out_last; o_none = b3.out_none; o_busy = b3.busy;
      end
      default: ;
    endcase
  end

  typedef struct {
    bit          do_rst;
    int          sel;
    bit          iv;
    logic [15:0] din;
    bit          ordy;
    bit          e_ir;
    bit          e_ov;
    logic [5:0]  e_idx;
    bit          e_last;
    bit          e_none;
  } row_t;

  row_t rows[$];

  task automatic add(input bit r, input int s, input bit v, input logic [15:0] d,
                     input bit o, input bit ir, input bit ov, input logic [5:0] ix,
                     input bit l, input bit n);
    row_t x;
    x.do_rst = r; x.sel = s; x.iv = v; x.din = d; x.ordy = o;
    x.e_ir = ir; x.e_ov = ov; x.e_idx = ix; x.e_last = l; x.e_none = n;
    rows.push_back(x);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  logic [15:0] vec [3];
  int          beat_idx[$];
  int          beat_cyc[$];
  int          k;
  int          exp_b2b_idx [3];
  bit          exp_ir;

  initial begin
    // Test 1: W8 MSB, 40 -> 5, 3; in_valid in SCAN (non-last) is ignored
    add(1,0,1,16'd40, 1, 1,0,0,0,0);
    add(0,0,1,16'd255,1, 0,1,5,0,0);
    add(0,0,0,16'd0,  1, 0,1,3,1,0);
    add(0,0,0,16'd0,  1, 1,0,0,0,0);
    // Test 2: all-zero vector -> single dummy beat
    add(1,0,1,16'd0,  1, 1,0,0,0,0);
    add(0,0,0,16'd0,  1, 0,1,0,1,1);
    add(0,0,0,16'd0,  1, 1,0,0,0,0);
    // Test 3: 150 with out_ready 1,0,0,1,1,0,1 -> 7,4,2,1
    add(1,0,1,16'd150,1, 1,0,0,0,0);
    add(0,0,0,16'd0,  1, 0,1,7,0,0);
    add(0,0,0,16'd0,  0, 0,1,4,0,0);
    add(0,0,0,16'd0,  0, 0,1,4,0,0);
    add(0,0,0,16'd0,  1, 0,1,4,0,0);
    add(0,0,0,16'd0,  1, 0,1,2,0,0);
    add(0,0,0,16'd0,  0, 0,1,1,1,0);
    add(0,0,0,16'd0,  1, 0,1,1,1,0);
    add(0,0,0,16'd0,  1, 1,0,0,0,0);
    // Test 4a: W8 LSB, 46 -> 1,2,3,5
    add(1,1,1,16'd46, 1, 1,0,0,0,0);
    add(0,1,0,16'd0,  1, 0,1,1,0,0);
    add(0,1,0,16'd0,  1, 0,1,2,0,0);
    add(0,1,0,16'd0,  1, 0,1,3,0,0);
    add(0,1,0,16'd0,  1, 0,1,5,1,0);
    add(0,1,0,16'd0,  1, 1,0,0,0,0);
    // Test 4b: W16, 8001 -> MSB: 15,0 ; LSB: 0,15
    add(1,2,1,16'h8001,1, 1,0,0,0,0);
    add(0,2,0,16'd0,  1, 0,1,15,0,0);
    add(0,2,0,16'd0,  1, 0,1,0,1,0);
    add(0,2,0,16'd0,  1, 1,0,0,0,0);
    add(1,3,1,16'h8001,1, 1,0,0,0,0);
    add(0,3,0,16'd0,  1, 0,1,0,0,0);
    add(0,3,0,16'd0,  1, 0,1,15,1,0);
    add(0,3,0,16'd0,  1, 1,0,0,0,0);

    // Reset state while rst_n is held low
    #3;
    check("rst in_ready",  64'(o_ir),   64'd1);
    check("rst out_valid", 64'(o_ov),   64'd0);
    check("rst out_index", 64'(o_idx),  64'd0);
    check("rst out_last",  64'(o_last), 64'd0);
    check("rst out_none",  64'(o_none), 64'd0);
    check("rst busy",      64'(o_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (rows[r]) begin
      @(negedge clk);
      if (rows[r].do_rst) begin
        iv = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      sel = rows[r].sel; iv = rows[r].iv; din = rows[r].din; ordy = rows[r].ordy;
      #1;
      exp_ir = rows[r].e_ir | (B2B & rows[r].e_ov & rows[r].ordy & rows[r].e_last);
      check($sformatf("row%0d in_ready", r),  64'(o_ir),   64'(exp_ir));
      check($sformatf("row%0d out_valid", r), 64'(o_ov),   64'(rows[r].e_ov));
      check($sformatf("row%0d out_index", r), 64'(o_idx),  64'(rows[r].e_idx));
      check($sformatf("row%0d out_last", r),  64'(o_last), 64'(rows[r].e_last));
      check($sformatf("row%0d out_none", r),  64'(o_none), 64'(rows[r].e_none));
      check($sformatf("row%0d busy", r),      64'(o_busy), 64'(rows[r].e_ov));
    end

    // Test 5: reset mid-scan of 255 after two beats
    @(negedge clk);
    iv = 1'b0; rst_n = 1'b0; #1; rst_n = 1'b1;
    sel = 0; iv = 1'b1; din = 16'd255; ordy = 1'b1;
    #1;
    check("t5 accept in_ready", 64'(o_ir), 64'd1);
    @(negedge clk);
    iv = 1'b0; din = '0;
    #1;
    check("t5 beat1 index", 64'(o_idx), 64'd7);
    @(negedge clk);
    #1;
    check("t5 beat2 index", 64'(o_idx), 64'd6);
    @(negedge clk);
    #1;
    check("t5 pre-reset out_valid", 64'(o_ov), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5 rst out_valid", 64'(o_ov),   64'd0);
    check("t5 rst busy",      64'(o_busy), 64'd0);
    check("t5 rst in_ready",  64'(o_ir),   64'd1);
    check("t5 rst out_index", 64'(o_idx),  64'd0);
    check("t5 rst out_last",  64'(o_last), 64'd0);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("t5 post%0d out_valid", c), 64'(o_ov), 64'd0);
      check($sformatf("t5 post%0d in_ready", c),  64'(o_ir), 64'd1);
    end

    // Test 6: streaming 1, 2, 64 with in_valid held high
    vec[0] = 16'd1; vec[1] = 16'd2; vec[2] = 16'd64;
    exp_b2b_idx[0] = 0; exp_b2b_idx[1] = 1; exp_b2b_idx[2] = 6;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      sel = 0; ordy = 1'b1;
      iv  = (k < 3);
      din = (k < 3) ? vec[k] : 16'd0;
      #1;
      if (o_ov && ordy) begin
        beat_idx.push_back(int'(o_idx));
        beat_cyc.push_back(c);
      end
      if (iv && o_ir) k++;
    end
    iv = 1'b0;
    check("t6 beat count", 64'(beat_idx.size()), 64'd3);
    for (int i = 0; i < 3 && i < beat_idx.size(); i++)
      check($sformatf("t6 beat%0d index", i), 64'(beat_idx[i]), 64'(exp_b2b_idx[i]));
    for (int i = 1; i < 3 && i < beat_cyc.size(); i++)
      check($sformatf("t6 beat%0d spacing", i), 64'(beat_cyc[i] - beat_cyc[i-1]), 64'(GAP));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
